// File: rtl/audio_cen_scheduler.sv
// Central clock-enable scheduler for the audio resampling chain: one 15120-cycle
// frame phase drives every rate strobe, plus the CLEAR/SETTLE/RUN start-up sequence.
module audio_cen_scheduler #(
   parameter int CLR_CYCLES    = 16,
   parameter int SETTLE_FRAMES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        resync,
   output logic        cen240,
   output logic        cen48,
   output logic        cen144,
   output logic        cen1080,
   output logic        cen72,
   output logic        cen504,
   output logic        cen1008,
   output logic        cen252,
   output logic        cen63,
   output logic        cen9,
   output logic        filt_clr,
   output logic        mute,
   output logic [1:0]  state,
   output logic [13:0] phase
);

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } state_e;

   localparam int              NUM_DIV     = 10;
   localparam int              DIV_W       = 11;
   localparam int              CEN1008_IDX = 6;
   localparam logic [13:0]     PHASE_LAST  = 14'd15119;
   localparam logic [7:0]      CLR_LAST    = 8'(CLR_CYCLES - 1);
   localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_FRAMES - 1);

   // Reload values (N-1), bit order matches the strobe vector cen_q.
   localparam logic [DIV_W-1:0] DIV_LAST [NUM_DIV] = '{
      11'd239, 11'd47, 11'd143, 11'd1079, 11'd71,
      11'd503, 11'd1007, 11'd251, 11'd62, 11'd8
   };

   state_e             state_q, state_d;
   logic [13:0]        phase_q, phase_d;
   logic [7:0]         clr_cnt_q, clr_cnt_d;
   logic [7:0]         settle_cnt_q, settle_cnt_d;
   logic [NUM_DIV-1:0] cen_q, cen_d;
   logic [DIV_W-1:0]   div_cnt_q [NUM_DIV];
   logic [DIV_W-1:0]   div_cnt_d [NUM_DIV];
   logic               phase_wrap;

   assign phase_wrap = (phase_q == PHASE_LAST);

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      clr_cnt_d    = clr_cnt_q;
      settle_cnt_d = settle_cnt_q;
      cen_d        = '0;
      div_cnt_d    = div_cnt_q;

      if (resync) begin
         state_d      = ST_CLEAR;
         phase_d      = '0;
         clr_cnt_d    = '0;
         settle_cnt_d = '0;
         div_cnt_d    = DIV_LAST;
      end else if (enable) begin
         case (state_q)
            ST_CLEAR: begin
               if (clr_cnt_q == CLR_LAST) begin
                  clr_cnt_d = '0;
                  state_d   = (SETTLE_FRAMES == 0) ? ST_RUN : ST_SETTLE;
               end else begin
                  clr_cnt_d = clr_cnt_q + 8'd1;
               end
            end
            ST_SETTLE, ST_RUN: begin
               phase_d = phase_wrap ? 14'd0 : phase_q + 14'd1;
               // A divider at zero means phase mod N == N-1 before this step.
               for (int i = 0; i < NUM_DIV; i++) begin
                  cen_d[i]     = (div_cnt_q[i] == '0);
                  div_cnt_d[i] = (phase_wrap || div_cnt_q[i] == '0) ?
                                 DIV_LAST[i] : div_cnt_q[i] - 11'd1;
               end
               if (state_q == ST_SETTLE && cen_d[CEN1008_IDX]) begin
                  if (settle_cnt_q == SETTLE_LAST) begin
                     state_d      = ST_RUN;
                     settle_cnt_d = '0;
                  end else begin
                     settle_cnt_d = settle_cnt_q + 8'd1;
                  end
               end
            end
            default: state_d = ST_CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_CLEAR;
         phase_q      <= '0;
         clr_cnt_q    <= '0;
         settle_cnt_q <= '0;
         cen_q        <= '0;
         div_cnt_q    <= DIV_LAST;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         clr_cnt_q    <= clr_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         cen_q        <= cen_d;
         div_cnt_q    <= div_cnt_d;
      end
   end

   assign cen240   = cen_q[0];
   assign cen48    = cen_q[1];
   assign cen144   = cen_q[2];
   assign cen1080  = cen_q[3];
   assign cen72    = cen_q[4];
   assign cen504   = cen_q[5];
   assign cen1008  = cen_q[6];
   assign cen252   = cen_q[7];
   assign cen63    = cen_q[8];
   assign cen9     = cen_q[9];
   assign filt_clr = (state_q == ST_CLEAR);
   assign mute     = (state_q != ST_RUN);
   assign state    = state_q;
   assign phase    = phase_q;

endmodule
